inference_scheduler: RTL and testbench
======================================

INFERENCE_SCHEDULER -- requirements
Module: inference_scheduler

Interface
REQ-001 SHALL have parameter IN_ROWS, default 20, input frame height in pixels.
REQ-002 SHALL have parameter IN_COLS, default 20, input frame width in pixels.
REQ-003 SHALL have parameter OUT_ROWS, default 20, crop window height.
REQ-004 SHALL have parameter OUT_COLS, default 20, crop window width.
REQ-005 SHALL have parameter N_RESULTS, default 1, result beats per inference.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 1000000, cycles in RUN before abort.
REQ-007 SHALL have parameter RST_CYCLES, default 16, pipe_reset hold length.
REQ-008 clk  input  1  single clock; all logic on its rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 enable  input  1  permits new inferences to start.
REQ-011 sof  input  1  one-cycle start-of-frame pulse from the camera path.
REQ-012 cfg_we  input  1  crop-coordinate write strobe.
REQ-013 cfg_x0  input  $clog2(IN_COLS)  requested crop column origin.
REQ-014 cfg_y0  input  $clog2(IN_ROWS)  requested crop row origin.
REQ-015 err_clr  input  1  clears sticky error flags.
REQ-016 res_tvalid  input  1  CNN result-stream valid (monitored only).
REQ-017 res_tready  input  1  CNN result-stream ready (monitored only).
REQ-018 ap_start  output  1  one-cycle start pulse to the inference pipeline.
REQ-019 crop_x0  output  $clog2(IN_COLS)  active crop column, stable per frame.
REQ-020 crop_y0  output  $clog2(IN_ROWS)  active crop row, stable per frame.
REQ-021 busy  output  1  high in every state except IDLE.
REQ-022 done  output  1  one-cycle pulse when an inference completes.
REQ-023 pipe_reset  output  1  pipeline reset request after timeout.
REQ-024 frames_started  output  16  saturating count of issued ap_start pulses.
REQ-025 frames_dropped  output  16  saturating count of sof pulses rejected while busy.
REQ-026 timeout_err  output  1  sticky: an inference timed out.
REQ-027 cfg_err  output  1  sticky: an out-of-range configuration write was rejected.

Function
REQ-028 SHALL implement states IDLE, START, RUN and FLUSH.
REQ-029 IDLE with sof=1 and enable=1 SHALL go to START, copy the shadow coordinates to crop_x0/crop_y0, and clear the beat and timer counters.
REQ-030 START SHALL last exactly one cycle with ap_start=1, increment frames_started, then go to RUN; sof in cycle t gives ap_start in cycle t+1.
REQ-031 RUN SHALL count beats where res_tvalid=1 and res_tready=1; on beat N_RESULTS it SHALL pulse done and go to IDLE in the same edge.
REQ-032 RUN SHALL increment a timer every cycle; when the timer reaches TIMEOUT_CYCLES without completion, it SHALL set timeout_err and go to FLUSH.
REQ-033 FLUSH SHALL hold pipe_reset=1 for exactly RST_CYCLES cycles, then return to IDLE; ap_start SHALL never assert in FLUSH.
REQ-034 An sof in START, RUN or FLUSH SHALL be ignored and increment frames_dropped; an sof in IDLE with enable=0 SHALL be ignored and not counted.
REQ-035 A cfg_we SHALL update the shadow registers only if cfg_x0 <= IN_COLS-OUT_COLS and cfg_y0 <= IN_ROWS-OUT_ROWS; otherwise the shadow SHALL be unchanged and cfg_err set.
REQ-036 A cfg_we in the same cycle as an accepted sof SHALL be written through, so the new valid value is latched for that frame.
REQ-037 crop_x0/crop_y0 SHALL change only on the IDLE->START edge.
REQ-038 Both counters SHALL saturate at 0xFFFF and not wrap.
REQ-039 err_clr SHALL clear timeout_err and cfg_err; a set event in the same cycle SHALL win.
REQ-040 A result beat arriving in the same cycle as the timeout expiry SHALL complete normally: done pulses, no FLUSH.

Reset
REQ-041 reset SHALL force IDLE; clear ap_start, done, busy, pipe_reset, both counters, both error flags, shadow registers and crop outputs to 0; and take effect from any state, including mid-RUN or mid-FLUSH.

Verification (IN 64x64, OUT 32x32, N_RESULTS=1, TIMEOUT_CYCLES=100, RST_CYCLES=16)
REQ-042 Stimulus: cfg_we with x0=10, y0=20, then sof at cycle 5, then a result beat 30 cycles later. Response: ap_start at cycle 6; crop=(10,20) from cycle 6; done one cycle after the beat; frames_started=1.
REQ-043 Stimulus: 3 sof pulses during RUN. Response: frames_dropped=3; no extra ap_start.
REQ-044 Stimulus: no result beat after ap_start. Response: timeout_err=1 after 100 RUN cycles; pipe_reset high for 16 cycles; busy low afterwards.
REQ-045 Stimulus: cfg_we with x0=40, then sof. Response: cfg_err=1; crop_x0 keeps its previous value.
REQ-046 Stimulus: reset asserted mid-FLUSH. Response: next cycle pipe_reset=0, busy=0, all counters 0.
REQ-047 Stimulus: hold frames_dropped at 0xFFFF and send another sof while busy. Response: frames_dropped stays 0xFFFF.

Source files
------------

// File: rtl/inference_scheduler.sv
// Frame-level scheduler for a CNN inference pipeline: gates sof into ap_start,
// latches the crop window per frame, watches the result stream and recovers from hangs.
module inference_scheduler #(
    parameter int IN_ROWS        = 20,
    parameter int IN_COLS        = 20,
    parameter int OUT_ROWS       = 20,
    parameter int OUT_COLS       = 20,
    parameter int N_RESULTS      = 1,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int RST_CYCLES     = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       sof,
    input  logic                       cfg_we,
    input  logic [$clog2(IN_COLS)-1:0] cfg_x0,
    input  logic [$clog2(IN_ROWS)-1:0] cfg_y0,
    input  logic                       err_clr,
    input  logic                       res_tvalid,
    input  logic                       res_tready,
    output logic                       ap_start,
    output logic [$clog2(IN_COLS)-1:0] crop_x0,
    output logic [$clog2(IN_ROWS)-1:0] crop_y0,
    output logic                       busy,
    output logic                       done,
    output logic                       pipe_reset,
    output logic [15:0]                frames_started,
    output logic [15:0]                frames_dropped,
    output logic                       timeout_err,
    output logic                       cfg_err
);

    localparam int XW = $clog2(IN_COLS);
    localparam int YW = $clog2(IN_ROWS);
    localparam int BW = $clog2(N_RESULTS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(RST_CYCLES + 1);

    localparam logic [XW-1:0] X_MAX     = XW'(IN_COLS - OUT_COLS);
    localparam logic [YW-1:0] Y_MAX     = YW'(IN_ROWS - OUT_ROWS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(N_RESULTS - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] LAST_RST  = RW'(RST_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, START, RUN, FLUSH} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] beats_q, beats_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [XW-1:0] shadow_x_q, shadow_x_d, crop_x_q, crop_x_d;
    logic [YW-1:0] shadow_y_q, shadow_y_d, crop_y_q, crop_y_d;
    logic          done_q, done_d;
    logic [15:0]   started_q, started_d, dropped_q, dropped_d;
    logic          timeout_err_q, timeout_err_d, cfg_err_q, cfg_err_d;

    logic cfg_ok, cfg_wr, beat, timeout_set;

    always_comb begin
        state_d       = state_q;
        beats_d       = beats_q;
        timer_d       = timer_q;
        rst_cnt_d     = rst_cnt_q;
        shadow_x_d    = shadow_x_q;
        shadow_y_d    = shadow_y_q;
        crop_x_d      = crop_x_q;
        crop_y_d      = crop_y_q;
        done_d        = 1'b0;
        started_d     = started_q;
        dropped_d     = dropped_q;
        timeout_set   = 1'b0;

        cfg_ok = (cfg_x0 <= X_MAX) && (cfg_y0 <= Y_MAX);
        cfg_wr = cfg_we && cfg_ok;
        beat   = res_tvalid && res_tready;

        if (cfg_wr) begin
            shadow_x_d = cfg_x0;
            shadow_y_d = cfg_y0;
        end

        case (state_q)
            IDLE: begin
                if (sof && enable) begin
                    state_d  = START;
                    // shadow_*_d already carries a same-cycle valid write
                    crop_x_d = shadow_x_d;
                    crop_y_d = shadow_y_d;
                    beats_d  = '0;
                    timer_d  = '0;
                end
            end
            START: begin
                state_d = RUN;
                if (started_q != 16'hFFFF) started_d = started_q + 16'd1;
            end
            RUN: begin
                timer_d = timer_q + TW'(1);
                // A completing beat outranks a simultaneous timeout expiry
                if (beat && beats_q == LAST_BEAT) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    if (beat) beats_d = beats_q + BW'(1);
                    if (timer_q == LAST_TICK) begin
                        timeout_set = 1'b1;
                        rst_cnt_d   = '0;
                        state_d     = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (rst_cnt_q == LAST_RST) state_d = IDLE;
                else                       rst_cnt_d = rst_cnt_q + RW'(1);
            end
            default: state_d = IDLE;
        endcase

        if (sof && state_q != IDLE && dropped_q != 16'hFFFF)
            dropped_d = dropped_q + 16'd1;

        timeout_err_d = timeout_set ? 1'b1 : (err_clr ? 1'b0 : timeout_err_q);
        cfg_err_d     = (cfg_we && !cfg_ok) ? 1'b1 : (err_clr ? 1'b0 : cfg_err_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            beats_q       <= '0;
            timer_q       <= '0;
            rst_cnt_q     <= '0;
            shadow_x_q    <= '0;
            shadow_y_q    <= '0;
            crop_x_q      <= '0;
            crop_y_q      <= '0;
            done_q        <= 1'b0;
            started_q     <= '0;
            dropped_q     <= '0;
            timeout_err_q <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            beats_q       <= beats_d;
            timer_q       <= timer_d;
            rst_cnt_q     <= rst_cnt_d;
            shadow_x_q    <= shadow_x_d;
            shadow_y_q    <= shadow_y_d;
            crop_x_q      <= crop_x_d;
            crop_y_q      <= crop_y_d;
            done_q        <= done_d;
            started_q     <= started_d;
            dropped_q     <= dropped_d;
            timeout_err_q <= timeout_err_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    assign ap_start       = (state_q == START);
    assign busy           = (state_q != IDLE);
    assign pipe_reset     = (state_q == FLUSH);
    assign done           = done_q;
    assign crop_x0        = crop_x_q;
    assign crop_y0        = crop_y_q;
    assign frames_started = started_q;
    assign frames_dropped = dropped_q;
    assign timeout_err    = timeout_err_q;
    assign cfg_err        = cfg_err_q;

endmodule

// File: tb/tb_inference_scheduler.sv
// Directed bench for inference_scheduler: scoreboard queues hold expected ap_start
// (cycle, crop) and done cycles; a negedge monitor pops and compares them.
module tb_inference_scheduler;

    logic        clk = 1'b0;
    logic        reset, enable, sof, cfg_we, err_clr, res_tvalid, res_tready;
    logic [5:0]  cfg_x0, cfg_y0, crop_x0, crop_y0;
    logic        ap_start, busy, done, pipe_reset, timeout_err, cfg_err;
    logic [15:0] frames_started, frames_dropped;

    always #5 clk = ~clk;

    inference_scheduler #(
        .IN_ROWS(64), .IN_COLS(64), .OUT_ROWS(32), .OUT_COLS(32),
        .N_RESULTS(1), .TIMEOUT_CYCLES(100), .RST_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .sof(sof),
        .cfg_we(cfg_we), .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .err_clr(err_clr),
        .res_tvalid(res_tvalid), .res_tready(res_tready),
        .ap_start(ap_start), .crop_x0(crop_x0), .crop_y0(crop_y0),
        .busy(busy), .done(done), .pipe_reset(pipe_reset),
        .frames_started(frames_started), .frames_dropped(frames_dropped),
        .timeout_err(timeout_err), .cfg_err(cfg_err)
    );

    typedef struct {int x; int y; int at;} start_exp_t;
    start_exp_t start_q[$];
    int         done_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        start_exp_t e;
        int         d;
        if (ap_start === 1'b1) begin
            check("ap_start_expected", start_q.size() > 0, 1);
            if (start_q.size() > 0) begin
                e = start_q.pop_front();
                check("ap_start_cycle", cyc, e.at);
                check("crop_x0_at_start", crop_x0, e.x);
                check("crop_y0_at_start", crop_y0, e.y);
            end
        end
        if (done === 1'b1) begin
            check("done_expected", done_q.size() > 0, 1);
            if (done_q.size() > 0) begin
                d = done_q.pop_front();
                check("done_cycle", cyc, d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic sof_pulse(input bit accept, input int x, input int y);
        sof = 1'b1;
        if (accept) start_q.push_back('{x, y, cyc + 1});
        tick();
        sof = 1'b0;
    endtask

    task automatic beat();
        res_tvalid = 1'b1;
        res_tready = 1'b1;
        done_q.push_back(cyc + 1);
        tick();
        res_tvalid = 1'b0;
        res_tready = 1'b0;
    endtask

    task automatic cfg_write(input logic [5:0] x, input logic [5:0] y, input logic clr);
        cfg_we = 1'b1; cfg_x0 = x; cfg_y0 = y; err_clr = clr;
        tick();
        cfg_we = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; enable = 1'b1; sof = 1'b0; cfg_we = 1'b0; err_clr = 1'b0;
        cfg_x0 = '0; cfg_y0 = '0; res_tvalid = 1'b0; res_tready = 1'b0;
        ticks(3);
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_ap_start", ap_start, 0);
        check("rst_done", done, 0);
        check("rst_pipe_reset", pipe_reset, 0);
        check("rst_started", frames_started, 0);
        check("rst_dropped", frames_dropped, 0);
        check("rst_errs", {timeout_err, cfg_err}, 0);
        check("rst_crop", {crop_x0, crop_y0}, 0);

        // basic frame: crop latched, done one cycle after the beat
        cfg_write(6'd10, 6'd20, 1'b0);
        while (cyc < 5) tick();
        sof_pulse(1, 10, 20);
        check("start_busy", busy, 1);
        ticks(25);
        res_tvalid = 1'b1;
        tick();
        res_tvalid = 1'b0;
        ticks(2);
        beat();
        tick();
        check("f1_done_drained", done_q.size(), 0);
        check("f1_started", frames_started, 1);
        check("f1_idle", busy, 0);

        // sof while running is dropped
        sof_pulse(1, 10, 20);
        ticks(3);
        for (int i = 0; i < 3; i++) begin
            sof_pulse(0, 0, 0);
            tick();
        end
        check("drop3", frames_dropped, 3);
        beat();
        ticks(2);
        check("f2_started", frames_started, 2);
        check("f2_start_drained", start_q.size(), 0);

        // timeout: 100 RUN cycles then 16 FLUSH cycles, sof in FLUSH dropped
        sof_pulse(1, 10, 20);
        ticks(100);
        check("to_not_yet", timeout_err, 0);
        check("to_flush_not_yet", pipe_reset, 0);
        tick();
        check("to_err_set", timeout_err, 1);
        n = 0;
        while (pipe_reset === 1'b1 && n < 100) begin
            sof = (n == 5);
            n++;
            tick();
        end
        sof = 1'b0;
        check("flush_len", n, 16);
        check("flush_then_idle", busy, 0);
        check("flush_drop", frames_dropped, 4);

        // err_clr vs set in the same cycle; rejected config keeps old shadow
        cfg_write(6'd40, 6'd5, 1'b1);
        check("clr_timeout", timeout_err, 0);
        check("cfg_err_set_wins", cfg_err, 1);
        sof_pulse(1, 10, 20);
        ticks(3);
        beat();
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("cfg_err_cleared", cfg_err, 0);
        cfg_write(6'd0, 6'd33, 1'b0);
        check("cfg_err_y", cfg_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // boundary config written through on the accepting sof; later write held off
        cfg_we = 1'b1; cfg_x0 = 6'd32; cfg_y0 = 6'd32;
        sof_pulse(1, 32, 32);
        cfg_we = 1'b0;
        check("boundary_cfg_ok", cfg_err, 0);
        cfg_write(6'd1, 6'd2, 1'b0);
        ticks(3);
        check("crop_x_stable", crop_x0, 32);
        check("crop_y_stable", crop_y0, 32);
        beat();
        tick();

        // beat in the expiry cycle completes normally
        sof_pulse(1, 1, 2);
        ticks(100);
        beat();
        check("race_no_flush", pipe_reset, 0);
        check("race_no_timeout", timeout_err, 0);
        check("race_idle", busy, 0);
        tick();

        // disabled sof in IDLE: ignored, not counted
        enable = 1'b0;
        sof_pulse(0, 0, 0);
        tick();
        check("disabled_no_drop", frames_dropped, 4);
        check("disabled_idle", busy, 0);
        enable = 1'b1;

        // reset in the middle of FLUSH
        sof_pulse(1, 1, 2);
        n = 0;
        while (pipe_reset !== 1'b1 && n < 300) begin
            n++;
            tick();
        end
        check("reach_flush", pipe_reset, 1);
        ticks(3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_pipe_reset", pipe_reset, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_counters", {frames_started, frames_dropped}, 0);
        check("mid_rst_errs", {timeout_err, cfg_err}, 0);
        check("mid_rst_crop", {crop_x0, crop_y0}, 0);

        // drive frames_dropped to saturation, then keep dropping
        sof = 1'b1;
        for (int i = 0; i < 90000 && frames_dropped !== 16'hFFFF; i++) begin
            enable = !busy;
            if (!busy) start_q.push_back('{0, 0, cyc + 1});
            tick();
        end
        check("sat_reached", frames_dropped, 16'hFFFF);
        for (int i = 0; i < 5; i++) begin
            enable = !busy;
            if (!busy) start_q.push_back('{0, 0, cyc + 1});
            tick();
        end
        check("sat_held", frames_dropped, 16'hFFFF);
        sof = 1'b0;
        enable = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("final_start_drained", start_q.size(), 0);
        check("final_done_drained", done_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
